// File: rtl/tt_um_karthik_serial_adder.sv
// Bit-serial WIDTH-bit adder (LSB first) with accumulate mode, Tiny Tapeout top.
// Optional subtract mode is built when SADD_SUB_EN is defined.
module tt_um_karthik_serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] result_sum;
  logic             carry;
  logic             result_carry;
  logic             done;
  logic             busy;
  logic [2:0]       count;

  logic             start;
  logic             acc_mode;
  logic             s_bit;
  logic             c_next;
  logic             last;
  logic             capture;
  logic [WIDTH:0]   sum_cat;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic             carry_cap;
  logic [3:0]       sum_ext;
  logic             unused;

  assign start    = uio_in[0];
  assign acc_mode = uio_in[1];
  assign a_in     = ui_in[WIDTH-1:0];
  assign b_in     = ui_in[4 +: WIDTH];

  assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next = (a_sr[0] & b_sr[0])
                | (carry & (a_sr[0] ^ b_sr[0]));

  assign sum_cat  = {s_bit, sum_sr};
  assign sum_next = sum_cat[WIDTH:1];

  assign last = (state == SHIFT)
             && (count == 3'(WIDTH - 1));

  assign capture = start
                && ((state == IDLE) || last);

  // A back-to-back accumulate must see the sum finishing this edge.
  assign acc_src = last ? sum_next : result_sum;
  assign a_cap   = acc_mode ? acc_src : a_in;

`ifdef SADD_SUB_EN
  logic sub;
  assign sub       = uio_in[2];
  assign b_cap     = sub ? ~b_in : b_in;
  assign carry_cap = sub;
`else
  assign b_cap     = b_in;
  assign carry_cap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      sum_sr       <= '0;
      carry        <= 1'b0;
      count        <= '0;
      result_sum   <= '0;
      result_carry <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (last) begin
        result_sum   <= sum_next;
        result_carry <= c_next;
        done         <= 1'b1;
      end
      if (capture) begin
        a_sr   <= a_cap;
        b_sr   <= b_cap;
        carry  <= carry_cap;
        sum_sr <= '0;
        count  <= '0;
        state  <= SHIFT;
        busy   <= 1'b1;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_next;
        carry  <= c_next;
        count  <= count + 3'd1;
        if (last) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

  assign sum_ext = 4'(result_sum);

  assign uo_out  = {1'b0, busy, done,
                    result_carry, sum_ext};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign unused = &{1'b0, ui_in, uio_in};

endmodule
